// File: rtl/scan7seg_pkg.sv
// Shared types and constants for the multiplexed 4-digit seven-segment scanner.
package scan7seg_pkg;

  localparam int CNT_W = 26;

  typedef enum logic {
    IDLE,
    SCAN
  } state_t;

  typedef logic [3:0][7:0] seg_arr_t;

  localparam logic [3:0] DIG_OFF = 4'b1111;

  // Active-low one-hot enable for the addressed digit.
  function automatic logic [3:0] dig_sel(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/scan7seg_timer.sv
// Slot timing: counter within a digit slot, sub-slot index for brightness,
// digit index, and the end-of-slot / end-of-frame strobes.
module scan7seg_timer
  import scan7seg_pkg::*;
#(
  parameter logic [CNT_W-1:0] TICK_MAX = 26'd99999
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             run,
  output logic [CNT_W-1:0] cnt,
  output logic [2:0]       sub_idx,
  output logic [1:0]       dig_idx,
  output logic             frame_end
);

  localparam logic [CNT_W-1:0] SUB = (TICK_MAX + 26'd1) / 26'd8;

  logic [CNT_W-1:0] sub_cnt;
  logic             slot_end;

  assign slot_end  = run && (cnt == TICK_MAX);
  assign frame_end = slot_end && (dig_idx == 2'd3);

  // The sub-slot index is tracked with its own small counter so no divider
  // is needed when SUB is not a power of two.
  always_ff @(posedge clk) begin
    if (!nrst || !run) begin
      cnt     <= '0;
      sub_cnt <= '0;
      sub_idx <= '0;
      dig_idx <= '0;
    end else if (slot_end) begin
      cnt     <= '0;
      sub_cnt <= '0;
      sub_idx <= '0;
      dig_idx <= dig_idx + 2'd1;
    end else begin
      cnt <= cnt + 26'd1;
      if (sub_cnt == SUB - 26'd1) begin
        sub_cnt <= '0;
        sub_idx <= sub_idx + 3'd1;
      end else begin
        sub_cnt <= sub_cnt + 26'd1;
      end
    end
  end

endmodule

// File: rtl/scan7seg_ctrl.sv
// Scan controller: IDLE/SCAN FSM, frame-synchronous shadow buffer with
// load handshake, and registered segment/digit drivers.
module scan7seg_ctrl
  import scan7seg_pkg::*;
#(
  parameter logic [CNT_W-1:0] TICK_MAX  = 26'd99999,
  parameter logic [CNT_W-1:0] BLANK_CYC = 26'd250
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       enable,
  input  seg_arr_t   seg_in,
  input  logic       load_req,
  input  logic [2:0] bright,
  output logic       load_ack,
  output logic [7:0] seg,
  output logic [3:0] dig,
  output logic       frame_done
);

  state_t           state;
  seg_arr_t         shadow;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       sub_idx;
  logic [1:0]       dig_idx;
  logic             frame_end;
  logic             run;
  logic             lit;
  logic             boundary;

  // Dropping enable stops the timer immediately, so counters clear and the
  // outputs go dark on the very next edge even though the FSM lags a cycle.
  assign run      = (state == SCAN) && enable;
  assign lit      = run && (cnt >= BLANK_CYC) && (sub_idx <= bright);
  assign boundary = (state == IDLE) || frame_end;

  assign load_ack   = nrst && load_req && boundary;
  assign frame_done = nrst && frame_end;

  scan7seg_timer #(
    .TICK_MAX(TICK_MAX)
  ) u_timer (
    .clk      (clk),
    .nrst     (nrst),
    .run      (run),
    .cnt      (cnt),
    .sub_idx  (sub_idx),
    .dig_idx  (dig_idx),
    .frame_end(frame_end)
  );

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state  <= IDLE;
      shadow <= '0;
      seg    <= 8'h00;
      dig    <= DIG_OFF;
    end else begin
      case (state)
        IDLE:    if (enable) state <= SCAN;
        SCAN:    if (!enable) state <= IDLE;
        default: state <= IDLE;
      endcase
      if (load_ack) shadow <= seg_in;
      seg <= lit ? shadow[dig_idx] : 8'h00;
      dig <= lit ? dig_sel(dig_idx) : DIG_OFF;
    end
  end

endmodule

// File: tb/tb_scan7seg_ctrl.sv
// Self-checking bench for scan7seg_ctrl: a stimulus table, directed corner
// sequences and a randomized run, all scored against a timeline-based model.
module tb_scan7seg_ctrl;
  import scan7seg_pkg::*;

  localparam int SLOT   = 16;
  localparam int SUBLEN = SLOT / 8;
  localparam int BLANK  = 1;
  localparam int FRAME  = 4 * SLOT;

  logic       clk;
  logic       nrst;
  logic       enable;
  seg_arr_t   seg_in;
  logic       load_req;
  logic [2:0] bright;
  logic       load_ack;
  logic [7:0] seg;
  logic [3:0] dig;
  logic       frame_done;

  int checks;
  int failures;

  logic       act_ack, act_fd;
  logic       exp_ack, exp_fd;
  logic [7:0] exp_seg;
  logic [3:0] exp_dig;

  logic       m_scan;
  int         m_t;
  logic [7:0] m_shadow [4];

  scan7seg_ctrl #(
    .TICK_MAX (26'd15),
    .BLANK_CYC(26'd1)
  ) dut (
    .clk       (clk),
    .nrst      (nrst),
    .enable    (enable),
    .seg_in    (seg_in),
    .load_req  (load_req),
    .bright    (bright),
    .load_ack  (load_ack),
    .seg       (seg),
    .dig       (dig),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: m_t is the number of enabled cycles spent in SCAN, modulo a frame.
  task automatic model_step(input logic n, input logic e, input logic l,
                            input logic [2:0] b, input seg_arr_t s);
    int   cnt;
    int   digit;
    logic active;
    logic lit;
    cnt   = m_t % SLOT;
    digit = (m_t / SLOT) % 4;
    if (!n) begin
      exp_ack = 1'b0;
      exp_fd  = 1'b0;
      exp_seg = 8'h00;
      exp_dig = 4'hF;
      m_scan  = 1'b0;
      m_t     = 0;
      for (int i = 0; i < 4; i++) m_shadow[i] = 8'h00;
    end else begin
      active  = m_scan && e;
      exp_fd  = active && (cnt == SLOT - 1) && (digit == 3);
      exp_ack = l && (!m_scan || exp_fd);
      lit     = active && (cnt >= BLANK) && ((cnt / SUBLEN) <= int'(b));
      exp_seg = lit ? m_shadow[digit] : 8'h00;
      for (int k = 0; k < 4; k++) exp_dig[k] = !(lit && (k == digit));
      if (exp_ack) for (int i = 0; i < 4; i++) m_shadow[i] = s[i];
      if (!m_scan) begin
        m_scan = e;
        m_t    = 0;
      end else if (!e) begin
        m_scan = 1'b0;
        m_t    = 0;
      end else begin
        m_t = (m_t + 1) % FRAME;
      end
    end
  endtask

  // One clock cycle: drive, check strobes mid-cycle, then registered outputs after the edge.
  task automatic apply_stimulus(input logic n, input logic e, input logic l,
                                input logic [2:0] b, input seg_arr_t s);
    nrst     = n;
    enable   = e;
    load_req = l;
    bright   = b;
    seg_in   = s;
    #4;
    act_ack = load_ack;
    act_fd  = frame_done;
    model_step(n, e, l, b, s);
    check_output("load_ack", {7'd0, act_ack}, {7'd0, exp_ack});
    check_output("frame_done", {7'd0, act_fd}, {7'd0, exp_fd});
    @(posedge clk);
    #1;
    check_output("seg", seg, exp_seg);
    check_output("dig", {4'd0, dig}, {4'd0, exp_dig});
  endtask

  typedef struct {
    logic       n;
    logic       e;
    logic       l;
    logic [2:0] b;
    int         cycles;
    logic [3:0] dig;
    logic [7:0] seg;
    logic       ack;
    logic       fd;
  } vec_t;

  vec_t     vecs [12];
  seg_arr_t pat, newp, new2, rnd;
  int       nack;
  logic     got_fd, ack_at_fd;
  logic     r_n, r_e, r_l;
  logic [2:0] r_b;

  initial begin
    checks   = 0;
    failures = 0;
    m_scan   = 1'b0;
    m_t      = 0;
    for (int i = 0; i < 4; i++) m_shadow[i] = 8'h00;
    pat  = {8'h3F, 8'h06, 8'h5B, 8'h4F};
    newp = {8'h11, 8'h22, 8'h33, 8'h44};
    new2 = {8'hA1, 8'hB2, 8'hC3, 8'hD4};
    nrst = 1'b0; enable = 1'b1; load_req = 1'b0; bright = 3'd7; seg_in = pat;

    //            n     e     l     b     cyc  dig      seg    ack   fd
    vecs[0]  = '{1'b0, 1'b1, 1'b1, 3'd7, 3,  4'b1111, 8'h00, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 3'd7, 1,  4'b1111, 8'h00, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 3'd7, 1,  4'b1111, 8'h00, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 3'd7, 1,  4'b1111, 8'h00, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 3'd7, 1,  4'b1110, 8'h4F, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 3'd7, 14, 4'b1110, 8'h4F, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 3'd7, 1,  4'b1111, 8'h00, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 3'd7, 1,  4'b1101, 8'h5B, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 3'd7, 46, 4'b0111, 8'h3F, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 3'd0, 2,  4'b1110, 8'h4F, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 3'd0, 1,  4'b1111, 8'h00, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 3'd0, 1,  4'b1111, 8'h00, 1'b0, 1'b0};

    @(posedge clk);
    #1;

    for (int v = 0; v < 12; v++) begin
      for (int c = 0; c < vecs[v].cycles; c++)
        apply_stimulus(vecs[v].n, vecs[v].e, vecs[v].l, vecs[v].b, pat);
      check_output($sformatf("vec%0d_dig", v), {4'd0, dig}, {4'd0, vecs[v].dig});
      check_output($sformatf("vec%0d_seg", v), seg, vecs[v].seg);
      check_output($sformatf("vec%0d_ack", v), {7'd0, act_ack}, {7'd0, vecs[v].ack});
      check_output($sformatf("vec%0d_fd", v), {7'd0, act_fd}, {7'd0, vecs[v].fd});
    end

    // Load requested mid-frame waits for the frame boundary.
    for (int i = 0; i < 100 && !(m_scan && m_t == SLOT); i++) apply_stimulus(1, 1, 0, 3'd7, pat);
    check_output("midload_reach", {7'd0, m_scan && m_t == SLOT}, 8'd1);
    nack = 0; got_fd = 1'b0; ack_at_fd = 1'b0;
    for (int i = 0; i < 100 && !got_fd; i++) begin
      apply_stimulus(1, 1, 1, 3'd7, newp);
      if (act_ack) nack++;
      if (act_fd) begin
        got_fd    = 1'b1;
        ack_at_fd = act_ack;
      end
    end
    check_output("midload_fd_seen", {7'd0, got_fd}, 8'd1);
    check_output("midload_ack_count", nack[7:0], 8'd1);
    check_output("midload_ack_at_fd", {7'd0, ack_at_fd}, 8'd1);
    apply_stimulus(1, 1, 0, 3'd7, newp);
    apply_stimulus(1, 1, 0, 3'd7, newp);
    check_output("midload_new_seg", seg, 8'h44);
    check_output("midload_new_dig", {4'd0, dig}, 8'h0E);

    // Load request rising exactly on the frame_done cycle.
    for (int i = 0; i < 100 && m_t != FRAME - 1; i++) apply_stimulus(1, 1, 0, 3'd7, newp);
    apply_stimulus(1, 1, 1, 3'd7, new2);
    check_output("edgeload_fd", {7'd0, act_fd}, 8'd1);
    check_output("edgeload_ack", {7'd0, act_ack}, 8'd1);
    nack = 0;
    for (int i = 0; i < FRAME - 1; i++) begin
      apply_stimulus(1, 1, 1, 3'd7, new2);
      if (act_ack) nack++;
    end
    check_output("edgeload_no_second", nack[7:0], 8'd0);

    // Disable at digit 2, counter 7, then re-enable.
    for (int i = 0; i < 100 && m_t != 2 * SLOT + 7; i++) apply_stimulus(1, 1, 0, 3'd7, new2);
    apply_stimulus(1, 0, 0, 3'd7, new2);
    check_output("disable_dig", {4'd0, dig}, 8'h0F);
    check_output("disable_seg", seg, 8'h00);
    for (int i = 0; i < 3; i++) apply_stimulus(1, 0, 0, 3'd7, new2);
    nack = 0;
    for (int i = 0; i < 10 && dig === 4'hF; i++) begin
      apply_stimulus(1, 1, 0, 3'd7, new2);
      nack++;
    end
    check_output("reenable_latency", nack[7:0], 8'd3);
    check_output("reenable_seg", seg, 8'hD4);
    check_output("reenable_dig", {4'd0, dig}, 8'h0E);

    // Randomized run against the model.
    r_e = 1'b1;
    r_b = 3'd7;
    for (int i = 0; i < 1500; i++) begin
      r_n = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 49) == 0) r_e = ~r_e;
      if ($urandom_range(0, 19) == 0) r_b = 3'($urandom_range(0, 7));
      r_l = ($urandom_range(0, 7) == 0);
      rnd = {$urandom, $urandom};
      apply_stimulus(r_n, r_e, r_l, r_b, rnd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
